// File: rtl/lutram_march_ctrl_pkg.sv
// Shared encodings and per-element constants for the LUTRAM March C- sequencer.
// Element codes double as FSM state codes so the failing element can be
// reported straight from the state register.
package lutram_test_pkg;

    typedef enum logic [2:0] {
        ST_E0   = 3'd0,  // up,   write 0
        ST_E1   = 3'd1,  // up,   read 0 / write 1
        ST_E2   = 3'd2,  // up,   read 1 / write 0
        ST_E3   = 3'd3,  // down, read 0 / write 1
        ST_E4   = 3'd4,  // down, read 1 / write 0
        ST_E5   = 3'd5,  // up,   read 0
        ST_IDLE = 3'd6,
        ST_DONE = 3'd7
    } march_state_e;

    // Per-element property tables, bit index = state code (IDLE/DONE bits are 0).
    localparam logic [7:0] ELEM_UP   = 8'b0010_0111; // element walks addresses upward
    localparam logic [7:0] ELEM_RD   = 8'b0011_1110; // element has a read operation
    localparam logic [7:0] ELEM_WR   = 8'b0001_1111; // element has a write operation
    localparam logic [7:0] ELEM_EXP  = 8'b0001_0100; // expected read value
    localparam logic [7:0] ELEM_WVAL = 8'b0000_1010; // value written

    // Read-then-write elements take two cycles per address.
    function automatic logic elem_is_rw(input march_state_e s);
        return ELEM_RD[s] & ELEM_WR[s];
    endfunction

    // Element order of the March C- algorithm; E5 is followed by DONE.
    function automatic march_state_e next_elem(input march_state_e s);
        case (s)
            ST_E0:   return ST_E1;
            ST_E1:   return ST_E2;
            ST_E2:   return ST_E3;
            ST_E3:   return ST_E4;
            ST_E4:   return ST_E5;
            ST_E5:   return ST_DONE;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lutram_march_ctrl_if.sv
// Pin bundle between the March sequencer and the single-port LUTRAM.
// The sequencer drives address/data/write-enable; the RAM returns async read data.
interface lutram_march_ctrl_if #(
    parameter int A_WIDTH = 5
);
    logic [A_WIDTH-1:0] ram_a_o;
    logic               ram_d_o;
    logic               ram_we_o;
    logic               ram_q_i;

    modport master (output ram_a_o, output ram_d_o, output ram_we_o, input ram_q_i);
    modport slave  (input ram_a_o, input ram_d_o, input ram_we_o, output ram_q_i);
endinterface

// File: rtl/lutram_march_ctrl_addr_gen.sv
// Up/down address counter for the March walk. A load selects the direction and
// jumps to that direction's first address; last_o flags the terminal address.
module march_addr_gen #(
    parameter int A_WIDTH = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               up_i,
    input  logic               step_i,
    output logic [A_WIDTH-1:0] addr_o,
    output logic               last_o
);

    localparam logic [A_WIDTH-1:0] A_MAX = '1;

    logic up_q;

    // Address register: load has priority over step; direction is latched on load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_o <= '0;
            up_q   <= 1'b1;
        end else if (load_i) begin
            up_q   <= up_i;
            addr_o <= up_i ? '0 : A_MAX;
        end else if (step_i) begin
            addr_o <= up_q ? addr_o + A_WIDTH'(1) : addr_o - A_WIDTH'(1);
        end
    end

    assign last_o = up_q ? (addr_o == A_MAX) : (addr_o == '0);

endmodule

// File: rtl/lutram_march_ctrl.sv
// March C- sequencer for a single-port async-read LUTRAM. Owns the RAM pins,
// walks E0..E5, compares every read in the cycle its address is presented and
// reports pass/fail, a saturating miscompare count and the first failure.
module lutram_march_ctrl
    import lutram_test_pkg::*;
#(
    parameter int A_WIDTH = 5,
    parameter int ERR_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [ERR_W-1:0]   err_count_o,
    output logic [A_WIDTH-1:0] first_err_addr_o,
    output logic [2:0]         first_err_elem_o,
    lutram_march_ctrl_if.master ram
);

    march_state_e       state_q, state_d;
    logic               phase_q, phase_d;   // 0 = read phase, 1 = write phase
    logic               we_q, we_d;
    logic               d_q, d_d;
    logic               accept;
    logic               ag_load, ag_up, ag_step, ag_last;
    logic [A_WIDTH-1:0] addr;
    logic               rd_cycle;
    logic               miscmp;

    march_addr_gen #(.A_WIDTH(A_WIDTH)) u_addr_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (ag_load),
        .up_i   (ag_up),
        .step_i (ag_step),
        .addr_o (addr),
        .last_o (ag_last)
    );

    // Next-state, address-generator control and the RAM write pins for the next cycle.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        accept  = 1'b0;
        ag_load = 1'b0;
        ag_up   = 1'b1;
        ag_step = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = ST_E0;
                    phase_d = 1'b0;
                    ag_load = 1'b1;
                    ag_up   = 1'b1;
                end
            end
            default: begin
                if (elem_is_rw(state_q) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (ag_last) begin
                        // Element finished: next element starts at its own first address.
                        state_d = next_elem(state_q);
                        ag_load = (state_d != ST_DONE);
                        ag_up   = ELEM_UP[state_d];
                    end else begin
                        ag_step = 1'b1;
                    end
                end
            end
        endcase
        we_d = ELEM_WR[state_d] & (!elem_is_rw(state_d) | phase_d);
        d_d  = ELEM_WVAL[state_d];
    end

    // State, phase and registered RAM write pins; reset drops write-enable at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            we_q    <= 1'b0;
            d_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            we_q    <= we_d;
            d_q     <= d_d;
        end
    end

    assign rd_cycle = ELEM_RD[state_q] & (!elem_is_rw(state_q) | !phase_q);
    assign miscmp   = rd_cycle & (ram.ram_q_i != ELEM_EXP[state_q]);

    // Miscompare bookkeeping: saturating count, first failure location latched once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_count_o      <= '0;
            first_err_addr_o <= '0;
            first_err_elem_o <= '0;
        end else if (accept) begin
            err_count_o      <= '0;
            first_err_addr_o <= '0;
            first_err_elem_o <= '0;
        end else if (miscmp) begin
            if (err_count_o != '1) begin
                err_count_o <= err_count_o + ERR_W'(1);
            end
            if (err_count_o == '0) begin
                first_err_addr_o <= addr;
                first_err_elem_o <= state_q;
            end
        end
    end

    assign busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o = (state_q == ST_DONE);
    assign pass_o = done_o && (err_count_o == '0);

    assign ram.ram_a_o  = addr;
    assign ram.ram_we_o = we_q;
    assign ram.ram_d_o  = d_q;

endmodule

// File: tb/tb_lutram_march_ctrl.sv
// Directed bench for lutram_march_ctrl: behavioural LUTRAM with optional
// stuck-at faults, plus a second instance (ERR_W=2) whose RAM always reads 1.
module tb_lutram_march_ctrl;
    import lutram_test_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, done, pass;
    logic [7:0] err;
    logic [4:0] fea;
    logic [2:0] fee;
    logic       busy2, done2, pass2;
    logic [1:0] err2;
    logic [4:0] fea2;
    logic [2:0] fee2;
    int         fault;
    int         checks;
    int         errors;
    int         cyc;
    int         n;

    logic mem [32];

    lutram_march_ctrl_if #(.A_WIDTH(5)) ram_if ();
    lutram_march_ctrl_if #(.A_WIDTH(5)) ram2_if ();

    lutram_march_ctrl #(.A_WIDTH(5), .ERR_W(8)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .err_count_o      (err),
        .first_err_addr_o (fea),
        .first_err_elem_o (fee),
        .ram              (ram_if)
    );

    lutram_march_ctrl #(.A_WIDTH(5), .ERR_W(2)) dut2 (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .busy_o           (busy2),
        .done_o           (done2),
        .pass_o           (pass2),
        .err_count_o      (err2),
        .first_err_addr_o (fea2),
        .first_err_elem_o (fee2),
        .ram              (ram2_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural LUTRAM: synchronous write, asynchronous read, optional stuck-at cell.
    always @(posedge clk) begin
        if (ram_if.ram_we_o) mem[ram_if.ram_a_o] <= ram_if.ram_d_o;
    end
    assign ram_if.ram_q_i = (fault == 1 && ram_if.ram_a_o == 5'd5)  ? 1'b1 :
                            (fault == 2 && ram_if.ram_a_o == 5'd31) ? 1'b0 :
                            mem[ram_if.ram_a_o];
    assign ram2_if.ram_q_i = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then count busy cycles at negedges.
    task automatic run(input bit e0chk, input bit mid_pulse, input int rst_at, output int cycles);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 0;
        while (busy && cycles < 1000) begin
            if (e0chk && cycles < 32) begin
                chk("e0_we", 32'(ram_if.ram_we_o), 32'd1);
                chk("e0_addr", 32'(ram_if.ram_a_o), cycles);
                chk("e0_d", 32'(ram_if.ram_d_o), 32'd0);
            end
            if (mid_pulse && cycles == 100) start = 1'b1;
            if (mid_pulse && cycles == 101) start = 1'b0;
            if (rst_at > 0 && cycles == rst_at) break;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input string tag);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 1000), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        fault  = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_fea", 32'(fea), 0);
        chk("rst_fee", 32'(fee), 0);
        chk("rst_a", 32'(ram_if.ram_a_o), 0);
        chk("rst_d", 32'(ram_if.ram_d_o), 0);
        chk("rst_we", 32'(ram_if.ram_we_o), 0);
        @(negedge clk) rst_n = 1'b1;

        // Fault-free run with E0 write sweep checked.
        run(1'b1, 1'b0, 0, cyc);
        chk("clean_cycles", cyc, 320);
        chk("clean_done", 32'(done), 1);
        chk("clean_pass", 32'(pass), 1);
        chk("clean_err", 32'(err), 0);
        chk("clean_busy", 32'(busy), 0);
        chk("sat_done", 32'(done2), 1);
        chk("sat_err", 32'(err2), 3);
        chk("sat_fea", 32'(fea2), 0);
        chk("sat_fee", 32'(fee2), 1);
        chk("sat_pass", 32'(pass2), 0);

        // Address 5 stuck-at-1: E1, E3, E5 reads fail.
        fault = 1;
        run(1'b0, 1'b0, 0, cyc);
        chk("sa1_cycles", cyc, 320);
        chk("sa1_done", 32'(done), 1);
        chk("sa1_err", 32'(err), 3);
        chk("sa1_fea", 32'(fea), 5);
        chk("sa1_fee", 32'(fee), 1);
        chk("sa1_pass", 32'(pass), 0);

        // Address 31 stuck-at-0: E2, E4 reads fail.
        fault = 2;
        run(1'b0, 1'b0, 0, cyc);
        chk("sa0_cycles", cyc, 320);
        chk("sa0_err", 32'(err), 2);
        chk("sa0_fea", 32'(fea), 31);
        chk("sa0_fee", 32'(fee), 2);
        chk("sa0_pass", 32'(pass), 0);

        // Start pulse while busy is ignored.
        fault = 0;
        run(1'b0, 1'b1, 0, cyc);
        chk("mid_cycles", cyc, 320);
        chk("mid_done", 32'(done), 1);
        chk("mid_pass", 32'(pass), 1);
        chk("mid_err", 32'(err), 0);

        // Start held high across DONE: one DONE cycle then restart with cleared counters.
        fault = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        chk("held_busy0", 32'(busy), 1);
        wait_done("held_to1");
        chk("held_done", 32'(done), 1);
        chk("held_err1", 32'(err), 3);
        chk("held_idle", 32'(busy), 0);
        @(negedge clk);
        chk("held_rebusy", 32'(busy), 1);
        chk("held_redone", 32'(done), 0);
        chk("held_clr_err", 32'(err), 0);
        chk("held_clr_fea", 32'(fea), 0);
        chk("held_clr_fee", 32'(fee), 0);
        start = 1'b0;
        wait_done("held_to2");
        chk("held_err2", 32'(err), 3);
        chk("held_fee2", 32'(fee), 1);

        // Asynchronous reset at cycle 150 of a run.
        fault = 0;
        run(1'b0, 1'b0, 150, cyc);
        chk("abort_cycle", cyc, 150);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_pass", 32'(pass), 0);
        chk("abort_err", 32'(err), 0);
        chk("abort_fea", 32'(fea), 0);
        chk("abort_fee", 32'(fee), 0);
        chk("abort_a", 32'(ram_if.ram_a_o), 0);
        chk("abort_d", 32'(ram_if.ram_d_o), 0);
        chk("abort_we", 32'(ram_if.ram_we_o), 0);
        chk("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk) rst_n = 1'b1;
        run(1'b0, 1'b0, 0, cyc);
        chk("post_cycles", cyc, 320);
        chk("post_pass", 32'(pass), 1);
        chk("post_err", 32'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lutram_march_ctrl.md
# lutram_march_ctrl

Self-checking March C- sequencer for a single-port asynchronous-read LUTRAM primitive (32x1 by default). It owns the RAM's address, data and write-enable pins, walks the six March C- elements, compares every read against the expected value, and reports pass/fail, a saturating error count and the location of the first failure. It sits between the board-level start/status logic and the LUTRAM under test, and replaces the open-loop clear/write/read sequencing used in bring-up.

## Interface
Parameters:
- A_WIDTH, 5, RAM address width; depth is 2**A_WIDTH.
- ERR_W, 8, error counter width; the counter saturates at all-ones.

Ports:
- clk_i, in, 1, single clock; also drives the RAM WCLK.
- rst_ni, in, 1, reset; asynchronous, active-low.
- start_i, in, 1, start request; level-sampled.
- busy_o, out, 1, test in progress.
- done_o, out, 1, test complete; holds until the next accepted start.
- pass_o, out, 1, valid while done_o is high; 1 when err_count_o is 0.
- err_count_o, out, ERR_W, number of miscompares, saturating.
- first_err_addr_o, out, A_WIDTH, address of the first miscompare.
- first_err_elem_o, out, 3, element code of the first miscompare.
- ram_a_o, out, A_WIDTH, RAM address.
- ram_d_o, out, 1, RAM write data.
- ram_we_o, out, 1, RAM write enable.
- ram_q_i, in, 1, RAM asynchronous read data for ram_a_o.

## Operation
- Reset value of every output is 0, and ram_we_o drops immediately on rst_ni low.
- Element codes and states:
  - IDLE.
  - E0 W0: up, write 0.
  - E1 R0W1_UP.
  - E2 R1W0_UP.
  - E3 R0W1_DN.
  - E4 R1W0_DN.
  - E5 R0_FIN: read 0.
  - DONE.
- start_i is accepted only in IDLE or DONE. Acceptance clears err_count_o, first_err_addr_o, first_err_elem_o, pass_o and done_o, and enters E0 at address 0.
- start_i is ignored while busy_o is high.
- Single-operation elements (E0, E5) take 1 cycle per address.
- Read-write elements (E1–E4) take 2 cycles per address, in a read phase then a write phase:
  - Read phase: ram_we_o=0, and ram_q_i is compared against the expected value.
  - Write phase: ram_we_o=1, ram_d_o = the complement of the value just read-expected.
  - The address advances only after the write phase.
- Up elements run addresses 0→2**A_WIDTH−1. Down elements run 2**A_WIDTH−1→0. E5 runs upward.
- An element ends when the terminal address completes its last phase. The next element starts at its own first address; there is no address wrap inside an element.
- Miscompare handling:
  - err_count_o increments unless it is already all-ones.
  - On the first miscompare since start (err_count_o==0), first_err_addr_o and first_err_elem_o latch the current address and element code.
- After E5 the block enters DONE: busy_o=0, done_o=1, pass_o=(err_count_o==0).
- Reset mid-test aborts the run and returns to IDLE with all outputs 0. RAM contents are undefined afterwards.

## Timing
- ram_a_o, ram_d_o and ram_we_o are registered. ram_q_i is combinational from ram_a_o, and the compare samples it in the same cycle that ram_a_o is presented.
- When start_i is sampled high at edge N:
  - busy_o rises at edge N+1, with E0 presenting address 0, ram_we_o=1 and ram_d_o=0.
- Run length for depth D: D + 4·2D + D = 10D cycles, which is 320 for D=32.
  - busy_o is high for exactly 320 cycles.
  - done_o rises on the same edge that busy_o falls.
- A miscompare in a read cycle at edge M updates the error outputs at edge M+1.
- If the last read miscompares, the error outputs update on the same edge as done_o, and pass_o reflects them.
- start_i held high across DONE restarts immediately. The block spends one cycle in DONE, then busy_o rises again.

## Structure
- Shared package lutram_test_pkg holds:
  - the element/state encoding (3-bit codes E0–E5 as above; IDLE and DONE encodings);
  - the per-element direction, expected-read and write-value constants.
- One sub-module, march_addr_gen: an A_WIDTH up/down counter with load-first-address and terminal-address flag, driven by the FSM.
- The RAM instance lives outside this block, in the board top.

## Test plan
- Fault-free behavioural RAM model, one start pulse:
  - busy_o high for 320 cycles, then done_o=1, pass_o=1, err_count_o=0.
  - Write sequence in E0 covers addresses 0..31 with ram_d_o=0.
- Address 5 stuck-at-1:
  - err_count_o=3 (E1, E3, E5 reads), first_err_addr_o=5, first_err_elem_o=1, pass_o=0.
- Address 31 stuck-at-0:
  - err_count_o=2 (E2, E4 reads), first_err_addr_o=31, first_err_elem_o=2.
- Model that always returns 1, with ERR_W=2:
  - err_count_o saturates at 3.
  - first_err_addr_o=0, first_err_elem_o=1.
- start_i pulsed at cycle 100 of a run: ignored; the run still completes at cycle 320.
  - start_i held high after DONE: the block restarts, and the counters clear on acceptance.
- rst_ni asserted at cycle 150:
  - ram_we_o, busy_o and all other outputs go to 0 asynchronously, and the state is IDLE.
  - A subsequent start produces a full 320-cycle clean pass.
